// File: rtl/banner_scroller_pkg.sv
// Shared definitions for the rotating banner: FSM encoding, default blank symbol,
// and a constant-foldable clog2 used to size address and counter fields.
package banner_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [4:0] BLANK_DEFAULT = 5'b10001;

  function automatic int banner_clog2(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    while (span < value) begin
      span   = span << 1;
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/banner_tick.sv
// Scroll prescaler: counts 0..TICK_DIV-1 while run is high and flags the last count
// as tick; clr forces the count back to zero, otherwise the count holds.
module banner_tick
  import banner_scroller_pkg::*;
#(
  parameter int TICK_DIV = 3000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = banner_clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 32'sd1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  logic [CW-1:0] count_r;

  assign tick = run & (count_r == LAST);

  // Prescaler count: cleared when idle, frozen when held, wraps on the last count
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (run) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/banner_scroller.sv
// Rotating banner engine: writable message store, scroll position and registered
// DIGITS-wide window. Optional bounce mode selected by defining BANNER_BOUNCE_EN.
module banner_scroller
  import banner_scroller_pkg::*;
#(
  parameter int               MSG_LEN    = 16,
  parameter int               SYM_W      = 5,
  parameter int               DIGITS     = 4,
  parameter int               TICK_DIV   = 3000000,
  parameter logic [SYM_W-1:0] BLANK_CODE = SYM_W'(BLANK_DEFAULT)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              pause,
  input  logic                              dir,
  input  logic                              wr_en,
  input  logic [banner_clog2(MSG_LEN)-1:0]  wr_addr,
  input  logic [SYM_W-1:0]                  wr_data,
  output logic [DIGITS*SYM_W-1:0]           window,
  output logic [banner_clog2(MSG_LEN)-1:0]  pos,
  output logic                              step,
  output logic                              wrap
);

  localparam int            AW       = banner_clog2(MSG_LEN);
  localparam logic [AW:0]   LEN_W    = (AW + 1)'(MSG_LEN);
  localparam logic [AW-1:0] LAST_POS = AW'(MSG_LEN - 32'sd1);
  localparam logic [AW-1:0] ONE_POS  = AW'(32'd1);

  state_e           state_r;
  state_e           nxt_s;
  logic             run_s;
  logic             clr_s;
  logic             tick_s;
  logic [SYM_W-1:0] msg_r [MSG_LEN];

`ifdef BANNER_BOUNCE_EN
  localparam logic [AW-1:0] TURN_POS = AW'(MSG_LEN - DIGITS);
  logic fwd_r;
  logic unused_dir_s;
  assign unused_dir_s = dir;
`endif

  // Circular index into the message store; pos + k never exceeds 2*MSG_LEN-2
  function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] base, input int k);
    logic [AW:0] sum;
    sum = {1'b0, base} + (AW + 1)'(k);
    if (sum >= LEN_W) begin
      sum = sum - LEN_W;
    end else begin
      sum = sum;
    end
    return sum[AW-1:0];
  endfunction

  // Mode decode; the prescaler follows the mode being entered so en/pause act at once
  always_comb begin
    nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_RUN, ST_HOLD: begin
        if (!en) begin
          nxt_s = ST_IDLE;
        end else if (pause) begin
          nxt_s = ST_HOLD;
        end else begin
          nxt_s = ST_RUN;
        end
      end
      default: nxt_s = ST_IDLE;
    endcase
  end

  assign run_s = (nxt_s == ST_RUN);
  assign clr_s = (nxt_s == ST_IDLE);

  // Mode register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_s;
    end
  end

  banner_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run_s),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Message store; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_r[i] <= BLANK_CODE;
      end
    end else if (wr_en && ({1'b0, wr_addr} < LEN_W)) begin
      msg_r[wr_addr] <= wr_data;
    end
  end

  // Position, direction and the step/wrap pulses that accompany each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
`ifdef BANNER_BOUNCE_EN
      fwd_r <= 1'b1;
`endif
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (tick_s) begin
`ifdef BANNER_BOUNCE_EN
        // At either end the tick is spent reversing, so the window never wraps
        if (fwd_r) begin
          if (pos == TURN_POS) begin
            fwd_r <= 1'b0;
            wrap  <= 1'b1;
          end else begin
            pos  <= pos + ONE_POS;
            step <= 1'b1;
          end
        end else begin
          if (pos == '0) begin
            fwd_r <= 1'b1;
            wrap  <= 1'b1;
          end else begin
            pos  <= pos - ONE_POS;
            step <= 1'b1;
          end
        end
`else
        step <= 1'b1;
        if (!dir) begin
          if (pos == LAST_POS) begin
            pos  <= '0;
            wrap <= 1'b1;
          end else begin
            pos <= pos + ONE_POS;
          end
        end else begin
          if (pos == '0) begin
            pos  <= LAST_POS;
            wrap <= 1'b1;
          end else begin
            pos <= pos - ONE_POS;
          end
        end
`endif
      end
    end
  end

  // Window refreshed every cycle from the current pos; digit 0 sits in the MSBs
  always_ff @(posedge clk) begin
    if (reset) begin
      window <= {DIGITS{BLANK_CODE}};
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        window[(DIGITS-1-k)*SYM_W +: SYM_W] <= msg_r[wrap_idx(pos, k)];
      end
    end
  end

endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller (MSG_LEN=8, DIGITS=4, SYM_W=5, TICK_DIV=4).
// Define BANNER_BOUNCE_EN for both bench and RTL to exercise the bounce sequence.
module tb_banner_scroller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        pause = 1'b0;
  logic        dir = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [4:0]  wr_data = 5'd0;
  logic [19:0] window;
  logic [2:0]  pos;
  logic        step;
  logic        wrap;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [19:0] BLANK4 = {4{5'b10001}};

  banner_scroller #(
    .MSG_LEN    (8),
    .SYM_W      (5),
    .DIGITS     (4),
    .TICK_DIV   (4),
    .BLANK_CODE (5'b10001)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .pause   (pause),
    .dir     (dir),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .window  (window),
    .pos     (pos),
    .step    (step),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; pause = 1'b0; dir = 1'b0; wr_en = 1'b0;
    cyc();
    n_cmp++;
    if (window !== BLANK4 || pos !== 3'd0) begin
      n_err++; $display("FAIL reset_state: window=%h pos=%0d expected window=%h pos=0", window, pos, BLANK4);
    end
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_cmp++;
      if ({step, wrap} !== 2'b00) begin
        n_err++; $display("FAIL idle_pulses: step=%b wrap=%b expected 0 0 (cycle %0d)", step, wrap, c);
      end
    end
    n_cmp++;
    if (window !== BLANK4 || pos !== 3'd0) begin
      n_err++; $display("FAIL idle_state: window=%h pos=%0d expected window=%h pos=0", window, pos, BLANK4);
    end
  endtask

  task automatic test_scroll_left();
    logic [2:0] exp_pos;
    logic [1:0] exp_sw;
    int         n_wrap;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 5'(i);
      cyc();
    end
    wr_en = 1'b0;
    cyc();
    n_cmp++;
    if (window !== {5'd0, 5'd1, 5'd2, 5'd3}) begin
      n_err++; $display("FAIL loaded_window: got %h expected %h", window, {5'd0, 5'd1, 5'd2, 5'd3});
    end
    dir = 1'b0; en = 1'b1;
    n_wrap = 0;
    for (int c = 1; c <= 32; c++) begin
      cyc();
      exp_pos = 3'((c / 4) % 8);
      exp_sw  = {((c % 4) == 0), (c == 32)};
      if (wrap === 1'b1) n_wrap++;
      n_cmp++;
      if (pos !== exp_pos) begin
        n_err++; $display("FAIL scroll_pos: got %0d expected %0d (cycle %0d)", pos, exp_pos, c);
      end
      n_cmp++;
      if ({step, wrap} !== exp_sw) begin
        n_err++; $display("FAIL scroll_pulses: step/wrap=%b expected %b (cycle %0d)", {step, wrap}, exp_sw, c);
      end
      if (c == 21) begin
        n_cmp++;
        if (window !== {5'd5, 5'd6, 5'd7, 5'd0}) begin
          n_err++; $display("FAIL window_wrap: got %h expected %h", window, {5'd5, 5'd6, 5'd7, 5'd0});
        end
      end
    end
    n_cmp++;
    if (n_wrap !== 1) begin
      n_err++; $display("FAIL wrap_count: got %0d expected 1", n_wrap);
    end
  endtask

  task automatic test_scroll_right();
    dir = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++;
      if ({step, wrap, pos} !== ((c == 4) ? {2'b11, 3'd7} : {2'b00, 3'd0})) begin
        n_err++; $display("FAIL reverse_step: step=%b wrap=%b pos=%0d at cycle %0d", step, wrap, pos, c);
      end
    end
    cyc();
    n_cmp++;
    if (window !== {5'd7, 5'd0, 5'd1, 5'd2}) begin
      n_err++; $display("FAIL reverse_window: got %h expected %h", window, {5'd7, 5'd0, 5'd1, 5'd2});
    end
  endtask

  task automatic test_pause_and_idle();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (step !== 1'b1 && k < 8);
    n_cmp++;
    if (step !== 1'b1 || pos !== 3'd6) begin
      n_err++; $display("FAIL sync_step: step=%b pos=%0d expected step=1 pos=6 within 8 cycles", step, pos);
    end
    cyc(); cyc();
    pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_cmp++;
      if (step !== 1'b0 || pos !== 3'd6) begin
        n_err++; $display("FAIL pause_hold: step=%b pos=%0d expected 0 6 (cycle %0d)", step, pos, c);
      end
    end
    pause = 1'b0;
    cyc();
    n_cmp++;
    if (step !== 1'b0) begin
      n_err++; $display("FAIL pause_early: step=%b expected 0", step);
    end
    cyc();
    n_cmp++;
    if (step !== 1'b1 || pos !== 3'd5) begin
      n_err++; $display("FAIL pause_resume: step=%b pos=%0d expected 1 5", step, pos);
    end
    cyc(); cyc();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_cmp++;
      if (step !== 1'b0 || pos !== 3'd5) begin
        n_err++; $display("FAIL idle_hold: step=%b pos=%0d expected 0 5 (cycle %0d)", step, pos, c);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++;
      if ({step, pos} !== ((c == 4) ? {1'b1, 3'd4} : {1'b0, 3'd5})) begin
        n_err++; $display("FAIL reenable: step=%b pos=%0d at cycle %0d (step due at 4 with pos 4)", step, pos, c);
      end
    end
  endtask

  task automatic test_write_on_step();
    cyc(); cyc(); cyc();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'd20;
    cyc();
    wr_en = 1'b0;
    n_cmp++;
    if (step !== 1'b1 || pos !== 3'd3 || window !== {5'd4, 5'd5, 5'd6, 5'd7}) begin
      n_err++; $display("FAIL write_step_edge: step=%b pos=%0d window=%h expected 1 3 %h", step, pos, window, {5'd4, 5'd5, 5'd6, 5'd7});
    end
    cyc();
    n_cmp++;
    if (window !== {5'd20, 5'd4, 5'd5, 5'd6}) begin
      n_err++; $display("FAIL write_window: got %h expected %h", window, {5'd20, 5'd4, 5'd5, 5'd6});
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    cyc();
    n_cmp++;
    if (pos !== 3'd0 || window !== BLANK4 || {step, wrap} !== 2'b00) begin
      n_err++; $display("FAIL mid_reset: pos=%0d window=%h step/wrap=%b expected 0 %h 00", pos, window, {step, wrap}, BLANK4);
    end
    reset = 1'b0; en = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++;
      if ({step, pos} !== ((c == 4) ? {1'b1, 3'd1} : {1'b0, 3'd0})) begin
        n_err++; $display("FAIL post_reset_step: step=%b pos=%0d at cycle %0d", step, pos, c);
      end
    end
    n_cmp++;
    if (window !== BLANK4) begin
      n_err++; $display("FAIL post_reset_msg: got %h expected %h", window, BLANK4);
    end
  endtask

`ifdef BANNER_BOUNCE_EN
  task automatic test_bounce();
    logic [2:0] exp_pos [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1};
    logic       exp_wr  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1;
    for (int t = 0; t < 11; t++) begin
      for (int c = 0; c < 4; c++) begin
        dir = ~dir;
        cyc();
      end
      n_cmp++;
      if ({pos, wrap, step} !== {exp_pos[t], exp_wr[t], ~exp_wr[t]}) begin
        n_err++; $display("FAIL bounce_tick: pos=%0d wrap=%b step=%b expected %0d %b %b (tick %0d)", pos, wrap, step, exp_pos[t], exp_wr[t], ~exp_wr[t], t);
      end
    end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_cmp++;
    if (pos !== 3'd0) begin
      n_err++; $display("FAIL bounce_reset: pos=%0d expected 0", pos);
    end
    cyc(); cyc(); cyc(); cyc();
    n_cmp++;
    if (pos !== 3'd1 || step !== 1'b1) begin
      n_err++; $display("FAIL bounce_fwd: pos=%0d step=%b expected 1 1", pos, step);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef BANNER_BOUNCE_EN
    test_bounce();
`else
    test_scroll_left();
    test_scroll_right();
    test_pause_and_idle();
    test_write_on_step();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
